// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM state encoding for alu_sequencer
package alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam logic [1:0] ST_WAIT_A  = 2'b00;
    localparam logic [1:0] ST_WAIT_B  = 2'b01;
    localparam logic [1:0] ST_WAIT_OP = 2'b10;
    localparam logic [1:0] ST_EXEC    = 2'b11;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU; carry/overflow ports exist only with ALU_SEQ_FLAGS_EN
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
`ifdef ALU_SEQ_FLAGS_EN
    output logic               o_carry,
    output logic               o_overflow,
`endif
    output logic [NB_DATA-1:0] o_result,
    output logic               o_err
);

    localparam int NB_SH = $clog2(NB_DATA);
    localparam int MSB   = NB_DATA - 1;

    logic [NB_DATA-1:0] w_add;
    logic [NB_DATA-1:0] w_sub;
    logic [NB_SH-1:0]   w_shamt;

    assign w_shamt = i_b[NB_SH-1:0];

`ifdef ALU_SEQ_FLAGS_EN
    // The extra top bit of each sum is the carry-out / borrow.
    logic [NB_DATA:0] w_sum;
    logic [NB_DATA:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_add  = w_sum[NB_DATA-1:0];
    assign w_sub  = w_diff[NB_DATA-1:0];

    // Carry/borrow and signed overflow only mean something for ADD and SUB.
    always_comb begin
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        if (i_op == NB_OP'(OP_ADD)) begin
            o_carry    = w_sum[NB_DATA];
            o_overflow = (i_a[MSB] == i_b[MSB]) && (w_add[MSB] != i_a[MSB]);
        end else if (i_op == NB_OP'(OP_SUB)) begin
            o_carry    = w_diff[NB_DATA];
            o_overflow = (i_a[MSB] != i_b[MSB]) && (w_sub[MSB] != i_a[MSB]);
        end
    end
`else
    assign w_add = i_a + i_b;
    assign w_sub = i_a - i_b;
`endif

    // Opcode decode; anything unrecognised yields zero and raises o_err.
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            NB_OP'(OP_ADD): o_result = w_add;
            NB_OP'(OP_SUB): o_result = w_sub;
            NB_OP'(OP_AND): o_result = i_a & i_b;
            NB_OP'(OP_OR):  o_result = i_a | i_b;
            NB_OP'(OP_XOR): o_result = i_a ^ i_b;
            NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
            NB_OP'(OP_SRL): o_result = i_a >> w_shamt;
            NB_OP'(OP_SRA): o_result = $signed(i_a) >>> w_shamt;
            default:        o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - loads A, B, opcode over one bus and registers the ALU result; flags need ALU_SEQ_FLAGS_EN
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_dato,
    input  logic               i_valid,
    input  logic               i_clear,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_zero,
    output logic               o_err,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    logic [1:0]         r_state;
    logic [NB_DATA-1:0] r_a;
    logic [NB_DATA-1:0] r_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_result;
    logic               r_err;
    logic               r_valid;

    logic [NB_DATA-1:0] w_result;
    logic               w_err;
    logic               w_load;

    // Results commit only when EXEC completes without an abort.
    assign w_load = (r_state == ST_EXEC) && !i_clear;

    // Operand/opcode capture and state sequencing; clear discards partial loads.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else if (i_clear) begin
            r_state <= ST_WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                ST_WAIT_A: if (i_valid) begin
                    r_a     <= i_dato;
                    r_state <= ST_WAIT_B;
                end
                ST_WAIT_B: if (i_valid) begin
                    r_b     <= i_dato;
                    r_state <= ST_WAIT_OP;
                end
                ST_WAIT_OP: if (i_valid) begin
                    r_op    <= i_dato[NB_OP-1:0];
                    r_state <= ST_EXEC;
                end
                default: r_state <= ST_WAIT_A;
            endcase
        end
    end

    // Result/err registers hold until the next completed EXEC; o_valid pulses once.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_result <= '0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_result <= w_result;
                r_err    <= w_err;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic w_carry;
    logic w_overflow;
    logic r_carry;
    logic r_overflow;
    logic r_zero;

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_core (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
        .o_result   (w_result),
        .o_err      (w_err)
    );

    // Flag registers update alongside the result.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_load) begin
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
            r_zero     <= (w_result == '0);
        end
    end

    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
    assign o_zero     = r_zero;
`else
    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_err    (w_err)
    );

    assign o_carry    = 1'b0;
    assign o_overflow = 1'b0;
    assign o_zero     = 1'b0;
`endif

    assign o_result = r_result;
    assign o_err    = r_err;
    assign o_valid  = r_valid;
    assign o_state  = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer; flag expectations follow ALU_SEQ_FLAGS_EN
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               i_rst;
    logic [NB_DATA-1:0] i_dato;
    logic               i_valid;
    logic               i_clear;
    logic [NB_DATA-1:0] o_result;
    logic               o_carry;
    logic               o_overflow;
    logic               o_zero;
    logic               o_err;
    logic               o_valid;
    logic [1:0]         o_state;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       e;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         nvalid;
    logic [7:0] stream [0:11];

    alu_sequencer #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_dato     (i_dato),
        .i_valid    (i_valid),
        .i_clear    (i_clear),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_zero     (o_zero),
        .o_err      (o_err),
        .o_valid    (o_valid),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        exp_t r;
        int   sa, sb, s;
        r  = '0;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        case (op)
            6'h20: begin
                s = int'(a) + int'(b); r.res = s[7:0]; r.c = (s > 255);
                s = sa + sb;           r.v = (s > 127) || (s < -128);
            end
            6'h22: begin
                s = int'(a) - int'(b); r.res = s[7:0]; r.c = (a < b);
                s = sa - sb;           r.v = (s > 127) || (s < -128);
            end
            6'h24: r.res = a & b;
            6'h25: r.res = a | b;
            6'h26: r.res = a ^ b;
            6'h27: r.res = ~(a | b);
            6'h02: r.res = a >> b[2:0];
            6'h03: begin
                r.res = a;
                for (int i = 0; i < int'(b[2:0]); i++) r.res = {r.res[7], r.res[7:1]};
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 8'h00);
        if (!FE) begin
            r.c = 1'b0; r.v = 1'b0; r.z = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard: every o_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!i_rst && o_valid) begin
            if (q.size() == 0) begin
                chk("valid_without_expect", {31'd0, o_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_result",   {24'd0, o_result},   {24'd0, e.res});
                chk("sb_carry",    {31'd0, o_carry},    {31'd0, e.c});
                chk("sb_overflow", {31'd0, o_overflow}, {31'd0, e.v});
                chk("sb_zero",     {31'd0, o_zero},     {31'd0, e.z});
                chk("sb_err",      {31'd0, o_err},      {31'd0, e.e});
            end
        end
    end

    task automatic drive(input logic [7:0] d);
        i_dato  = d;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        drive(a);
        drive(b);
        q.push_back(model(a, b, op));
        drive({2'b00, op});
        chk({tag, "_state_exec"}, {30'd0, o_state}, 32'd3);
        chk({tag, "_valid_early"}, {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_state_a"}, {30'd0, o_state}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_once"}, {31'd0, o_valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_result"},   {24'd0, o_result},   32'd0);
        chk({tag, "_valid"},    {31'd0, o_valid},    32'd0);
        chk({tag, "_state"},    {30'd0, o_state},    32'd0);
        chk({tag, "_carry"},    {31'd0, o_carry},    32'd0);
        chk({tag, "_overflow"}, {31'd0, o_overflow}, 32'd0);
        chk({tag, "_err"},      {31'd0, o_err},      32'd0);
        chk({tag, "_zero"},     {31'd0, o_zero},     {31'd0, FE});
    endtask

    initial begin
        i_rst   = 1'b1;
        i_dato  = '0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        i_rst = 1'b0;

        run_op("add_ovf",  8'h7F, 8'h01, OP_ADD);
        run_op("sub_zero", 8'h05, 8'h05, OP_SUB);
        run_op("sub_brw",  8'h03, 8'h05, OP_SUB);
        run_op("add_cry",  8'hF0, 8'h20, OP_ADD);
        run_op("and",      8'hF0, 8'h3C, OP_AND);
        run_op("nor",      8'h00, 8'h00, OP_NOR);
        run_op("sra",      8'h80, 8'h01, OP_SRA);
        run_op("srl",      8'h80, 8'h09, OP_SRL);

        // Abort after A with a simultaneous strobe: clear wins, last result kept.
        drive(8'h11);
        i_dato  = 8'h22;
        i_valid = 1'b1;
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        chk("clr_state",  {30'd0, o_state},  32'd0);
        chk("clr_result", {24'd0, o_result}, 32'h40);
        chk("clr_valid",  {31'd0, o_valid},  32'd0);
        @(posedge clk); #1;
        chk("clr_valid2", {31'd0, o_valid},  32'd0);
        run_op("post_clr", 8'h0C, 8'h0A, OP_XOR);

        run_op("illegal", 8'h12, 8'h34, 6'h3F);
        run_op("pre_rst", 8'h10, 8'h20, OP_ADD);

        // Reset asserted between edges while waiting for the opcode.
        drive(8'h44);
        drive(8'h55);
        chk("rst_wait_op", {30'd0, o_state}, 32'd2);
        #2 i_rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        i_rst = 1'b0;
        run_op("post_rst", 8'h01, 8'h02, OP_ADD);

        // Strobe held high: one result per four cycles, EXEC-cycle data dropped.
        stream = '{8'h7F, 8'h01, 8'h20, 8'hAA,
                   8'h30, 8'h10, 8'h22, 8'h55,
                   8'hF0, 8'h0F, 8'h27, 8'hFF};
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            i_dato  = stream[i];
            i_valid = 1'b1;
            if (i % 4 == 2) q.push_back(model(stream[i-2], stream[i-1], stream[i][5:0]));
            @(posedge clk); #1;
            if (o_valid) nvalid++;
            if (i % 4 == 3) chk("stream_valid_pos", {31'd0, o_valid}, 32'd1);
        end
        i_valid = 1'b0;
        chk("stream_count", nvalid, 32'd3);
        @(posedge clk); #1;
        chk("stream_idle", {30'd0, o_state}, 32'd0);

        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
